flags_register: RTL
===================

// Module: flags_register
// PURPOSE
// - CPU status-flag register directly upstream of the control logic: its flags[3:0] output is the flags
//   operand of the microcode ROM lookup (together with opcode and step).
// - Captures ALU flags under a per-flag update mask, loads from / drives onto the data bus, and
//   sets or clears carry directly.
// - Keeps a one-deep shadow copy for interrupt entry (save) and return (restore).
// - All state changes on the rising edge of clk, the same edge that advances the CPU datapath.
// PARAMETERS
// - BUS_WIDTH  8  data bus width; flags occupy bits [3:0], upper bits driven 0 when outputting.
// - FLAG_BITS  4  number of flags; fixed bit map: [0]=C carry, [1]=Z zero, [2]=V overflow, [3]=N negative.
// PORTS
// - clk         in     1          system clock; all updates on rising edge
// - rstn        in     1          asynchronous active-low reset
// - alu_flags   in     4          flags computed by ALU this cycle (C,Z,V,N map as above)
// - fl_calc     in     1          control-word bit: capture alu_flags under fl_mask
// - fl_mask     in     4          per-flag capture enable for fl_calc (1 = update that flag)
// - fl_load     in     1          control-word bit: load flags from bus[3:0]
// - fl_out      in     1          control-word bit: drive flags onto bus
// - fl_setc     in     1          set carry flag
// - fl_clrc     in     1          clear carry flag
// - fl_save     in     1          copy flags into shadow register
// - fl_restore  in     1          copy shadow register into flags
// - bus         inout  BUS_WIDTH  shared data bus
// - flags       out    4          current flags, registered; feeds control logic
// BEHAVIOUR
// - Reset (rstn=0, asynchronous, no clock needed): flags=4'b0000, shadow=4'b0000, bus released (z).
//   Output is held while rstn=0; on release, first capture happens on the next rising clk edge.
// - Latency: any update is visible on flags one clk edge after the strobe is sampled; no
//   combinational path from any input to flags.
// - Bus drive is combinational: bus = fl_out ? {(BUS_WIDTH-4)'b0, flags} : 'z. It reflects the
//   pre-edge flags value.
// - Next-state priority per edge, highest first; exactly one source writes flags:
//   1. fl_restore: flags <= shadow
//   2. fl_load: flags <= bus[3:0]. If fl_out is also 1, bus carries the current flags, so flags hold.
//   3. fl_calc: for each i, flags[i] <= fl_mask[i] ? alu_flags[i] : flags[i].
//      fl_calc with fl_mask=0 holds all flags.
//   4. fl_setc / fl_clrc: carry <= 1 / 0. Both asserted together: carry holds (defined no-op).
//      Other flags unaffected.
//   5. None asserted: hold.
// - Carry ops are merged into a lower-priority write. When fl_calc=1 and fl_mask[0]=0, fl_setc /
//   fl_clrc still act on C in the same edge. A higher-priority write that touches C overrides them.
// - Shadow:
//   - fl_save: shadow <= flags (pre-edge value), independent of the flags write in the same edge.
//   - fl_save together with fl_restore swaps: flags <= old shadow, shadow <= old flags.
// - Reset mid-operation: asynchronous clear wins over any strobe; pending strobes are lost, with
//   no partial update.
// - X-safety: strobes sampled as X must not be masked by the priority logic (simulation propagates X).
// TESTING
// - Reset: drive rstn=0 mid-cycle with flags=4'b1011 -> flags=0 and bus=z immediately, before any clk edge.
// - Masked calc: flags=4'b0000, alu_flags=4'b1111, fl_calc=1, fl_mask=4'b0101 -> flags=4'b0101
//   after one edge; fl_mask=0 -> unchanged.
// - Priority and carry:
//   - fl_load=1 (bus=8'h0A) with fl_calc=1 -> flags=4'b1010.
//   - fl_calc=1, fl_mask=4'b1110, alu_flags=4'b0000 with fl_setc=1 -> flags=4'b0001.
//   - fl_setc=1 with fl_clrc=1 -> C unchanged.
// - Bus out: flags=4'b0110, fl_out=1 -> bus=8'h06 in the same cycle; fl_out=1 with fl_load=1 -> flags hold 4'b0110.
// - Shadow: flags=4'b1001, fl_save -> shadow=4'b1001; calc to 4'b0010; fl_restore -> flags=4'b1001.
//   Save and restore together with flags=4'b0011, shadow=4'b1100 -> swapped.

Source files
------------

// File: rtl/flags_if.sv
// Control-word and flag signals between the sequencer and the status-flag register.
//   alu_flags  : flags computed by the ALU this cycle ([0]=C [1]=Z [2]=V [3]=N)
//   fl_calc    : capture alu_flags under fl_mask
//   fl_mask    : per-flag capture enable for fl_calc
//   fl_load    : load flags from the data bus
//   fl_out     : drive flags onto the data bus
//   fl_setc    : set carry
//   fl_clrc    : clear carry
//   fl_save    : copy flags into the shadow register
//   fl_restore : copy the shadow register into flags
//   flags      : current registered flags, returned to the control logic
interface flags_if #(
    parameter int unsigned FLAG_BITS = 4
);
    logic [FLAG_BITS-1:0] alu_flags;
    logic                 fl_calc;
    logic [FLAG_BITS-1:0] fl_mask;
    logic                 fl_load;
    logic                 fl_out;
    logic                 fl_setc;
    logic                 fl_clrc;
    logic                 fl_save;
    logic                 fl_restore;
    logic [FLAG_BITS-1:0] flags;

    // Sequencer side: issues strobes, observes flags.
    modport master (
        output alu_flags, fl_calc, fl_mask, fl_load, fl_out,
        output fl_setc, fl_clrc, fl_save, fl_restore,
        input  flags
    );

    // Register side: samples strobes, returns flags.
    modport slave (
        input  alu_flags, fl_calc, fl_mask, fl_load, fl_out,
        input  fl_setc, fl_clrc, fl_save, fl_restore,
        output flags
    );
endinterface

// File: rtl/flags_register.sv
// CPU status-flag register feeding the microcode ROM lookup.
// Captures ALU flags under a per-flag mask, loads from / drives onto the shared
// data bus, sets or clears carry directly, and keeps a one-deep shadow copy used
// on interrupt entry (save) and return (restore).
//   clk  : system clock, all updates on the rising edge
//   rstn : asynchronous active-low reset, clears flags and shadow, releases bus
//   ctl  : flags_if slave modport (strobes in, registered flags out)
//   bus  : shared data bus; flags occupy [3:0], upper bits driven 0 when driving
module flags_register #(
    parameter int unsigned BUS_WIDTH = 8,
    parameter int unsigned FLAG_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    flags_if.slave               ctl,
    inout  wire  [BUS_WIDTH-1:0] bus
);

    localparam int unsigned C_IDX = 0;

    logic [FLAG_BITS-1:0] flags_q;
    logic [FLAG_BITS-1:0] flags_d;
    logic [FLAG_BITS-1:0] shadow_q;
    logic [FLAG_BITS-1:0] shadow_d;

    logic [FLAG_BITS-1:0] load_val;
    logic [FLAG_BITS-1:0] calc_val;
    logic [FLAG_BITS-1:0] merged_val;
    logic                 carry_free;
    logic                 carry_next;
    logic                 bus_drive_c;
    logic                 unused_bus_hi;

    // Upper bus bits are never loaded into flags.
    assign unused_bus_hi = ^bus[BUS_WIDTH-1:FLAG_BITS];

    // Bus is released while reset is held, regardless of fl_out.
    assign bus_drive_c = ctl.fl_out & rstn;
    assign bus = bus_drive_c ? BUS_WIDTH'(flags_q) : {BUS_WIDTH{1'bz}};

    // Next-state selection. Ternaries rather than if/else so an X strobe
    // propagates into the next state instead of silently taking one branch.
    always_comb begin
        load_val   = '0;
        calc_val   = '0;
        merged_val = '0;
        carry_free = 1'b0;
        carry_next = 1'b0;
        flags_d    = flags_q;
        shadow_d   = shadow_q;

        // Loading while also driving the bus reads back our own value: hold.
        load_val = ctl.fl_out ? flags_q : bus[FLAG_BITS-1:0];

        // Masked capture; with fl_calc low this is simply the held value.
        calc_val = ctl.fl_calc
                 ? ((ctl.alu_flags & ctl.fl_mask) | (flags_q & ~ctl.fl_mask))
                 : flags_q;

        // Carry ops apply unless the calc write owns C this edge.
        // setc together with clrc cancels out and C holds.
        carry_free = ~(ctl.fl_calc & ctl.fl_mask[C_IDX]);
        carry_next = carry_free
                   ? ((ctl.fl_setc & ~ctl.fl_clrc) ? 1'b1
                     : (ctl.fl_clrc & ~ctl.fl_setc) ? 1'b0
                     : calc_val[C_IDX])
                   : calc_val[C_IDX];

        merged_val        = calc_val;
        merged_val[C_IDX] = carry_next;

        // restore > load > calc/carry > hold
        flags_d = ctl.fl_restore ? shadow_q
                : ctl.fl_load    ? load_val
                : merged_val;

        // Shadow always samples pre-edge flags, so save+restore swaps.
        shadow_d = ctl.fl_save ? flags_q : shadow_q;
    end

    // Flag and shadow state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flags_q  <= '0;
            shadow_q <= '0;
        end else begin
            flags_q  <= flags_d;
            shadow_q <= shadow_d;
        end
    end

    assign ctl.flags = flags_q;

endmodule
